// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port RAM.
//   dev1 (instruction fetch) and dev2 (load/store) raise a level request
//   and hold their address/data/we until they receive a one-cycle ack.
//   Ties are broken round-robin using the last served requester.
//   Requests are sampled in IDLE and mem_en rises the next cycle.
//   There is always at least one idle RAM cycle between grants.
// Ports:
//   clk, reset (sync, active-low)
//   devN_mem_en/addr/di/we  in   request from requester N
//   devN_do_ack             out  completion pulse to requester N
//   dev_do                  out  shared read data, valid with an ack
//   mem_addr/di/we/en       out  shared RAM port; mem_burst_en tied 0
//   mem_do_ack, mem_do      in   RAM completion and read data
//   timeout_err             out  one-cycle watchdog error pulse
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to enable a grant watchdog
//   that force-completes a grant after TIMEOUT cycles with all-ones data.
module mem_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dev1_mem_en,
  input  logic [ADDR_W-1:0] dev1_mem_addr,
  input  logic [DATA_W-1:0] dev1_mem_di,
  input  logic              dev1_mem_we,
  input  logic              dev2_mem_en,
  input  logic [ADDR_W-1:0] dev2_mem_addr,
  input  logic [DATA_W-1:0] dev2_mem_di,
  input  logic              dev2_mem_we,
  output logic              dev1_do_ack,
  output logic              dev2_do_ack,
  output logic [DATA_W-1:0] dev_do,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_di,
  output logic              mem_we,
  output logic              mem_en,
  output logic              mem_burst_en,
  input  logic              mem_do_ack,
  input  logic [DATA_W-1:0] mem_do,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;   // 1'b0 = dev1 served last, 1'b1 = dev2
  logic [1:0] mask_q, mask_d;           // {dev2, dev1} masked for one IDLE cycle
  logic       mem_en_q, mem_en_d;
  logic [1:0] req_masked;
  logic       tmo;                      // watchdog expiry in the current grant cycle
  logic       done;                     // current grant completes this cycle

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds (grant cycle - 1), so expiry lands on grant cycle TIMEOUT
  assign tmo = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counter: runs only while a grant is held, restarts per grant
  always_comb begin
    if ((state_q != IDLE) && (state_d != IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign done         = mem_do_ack | tmo;
  assign mem_burst_en = 1'b0;
  assign mem_en       = mem_en_q;

  // Next-state, round-robin pointer and one-cycle re-grant mask
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    mask_d     = 2'b00;
    req_masked = {dev2_mem_en, dev1_mem_en} & ~mask_q;
    case (state_q)
      IDLE: begin
        case (req_masked)
          2'b01:   state_d = GNT1;
          2'b10:   state_d = GNT2;
          2'b11:   state_d = last_gnt_q ? GNT1 : GNT2;
          default: state_d = IDLE;
        endcase
      end
      GNT1: begin
        if (done) begin
          state_d    = IDLE;
          last_gnt_d = 1'b0;
          mask_d     = 2'b01;
        end else begin
          state_d    = GNT1;
        end
      end
      GNT2: begin
        if (done) begin
          state_d    = IDLE;
          last_gnt_d = 1'b1;
          mask_d     = 2'b10;
        end else begin
          state_d    = GNT2;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_en_d = (state_d != IDLE);
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      mask_q     <= 2'b00;
      mem_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      mask_q     <= mask_d;
      mem_en_q   <= mem_en_d;
    end
  end

  // RAM port mux and completion signalling for the granted requester;
  // acks are suppressed while reset is asserted so an abandoned grant never acks
  always_comb begin
    mem_addr    = '0;
    mem_di      = '0;
    mem_we      = 1'b0;
    dev1_do_ack = 1'b0;
    dev2_do_ack = 1'b0;
    dev_do      = '0;
    timeout_err = 1'b0;
    case (state_q)
      GNT1: begin
        mem_addr    = dev1_mem_addr;
        mem_di      = dev1_mem_di;
        mem_we      = dev1_mem_we;
        dev1_do_ack = done & reset;
      end
      GNT2: begin
        mem_addr    = dev2_mem_addr;
        mem_di      = dev2_mem_di;
        mem_we      = dev2_mem_we;
        dev2_do_ack = done & reset;
      end
      default: begin
        mem_addr    = '0;
      end
    endcase
    if (dev1_do_ack | dev2_do_ack) begin
      // a real RAM ack wins over a watchdog expiry in the same cycle
      dev_do      = mem_do_ack ? mem_do : {DATA_W{1'b1}};
      timeout_err = ~mem_do_ack;
    end else begin
      dev_do      = '0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [31:0] DI1 = 32'hD1D1_0001;
  localparam logic [31:0] DI2 = 32'hD2D2_0002;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev1_mem_en, dev2_mem_en, dev1_mem_we, dev2_mem_we;
  logic [9:0]  dev1_mem_addr, dev2_mem_addr;
  logic [31:0] dev1_mem_di, dev2_mem_di;
  logic        dev1_do_ack, dev2_do_ack;
  logic [31:0] dev_do;
  logic [9:0]  mem_addr;
  logic [31:0] mem_di;
  logic        mem_we, mem_en, mem_burst_en;
  logic        mem_do_ack;
  logic [31:0] mem_do;
  logic        timeout_err;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .dev1_mem_en(dev1_mem_en), .dev1_mem_addr(dev1_mem_addr),
    .dev1_mem_di(dev1_mem_di), .dev1_mem_we(dev1_mem_we),
    .dev2_mem_en(dev2_mem_en), .dev2_mem_addr(dev2_mem_addr),
    .dev2_mem_di(dev2_mem_di), .dev2_mem_we(dev2_mem_we),
    .dev1_do_ack(dev1_do_ack), .dev2_do_ack(dev2_do_ack), .dev_do(dev_do),
    .mem_addr(mem_addr), .mem_di(mem_di), .mem_we(mem_we), .mem_en(mem_en),
    .mem_burst_en(mem_burst_en), .mem_do_ack(mem_do_ack), .mem_do(mem_do),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        rst;
    logic        e1;
    logic [9:0]  a1;
    logic        w1;
    logic        e2;
    logic [9:0]  a2;
    logic        w2;
    logic        mack;
    logic [31:0] mdo;
    logic [1:0]  gnt;    // expected granted requester, 0 = none
    logic [9:0]  xaddr;
    logic        k1;
    logic        k2;
    logic [31:0] xdo;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rst, logic e1, logic [9:0] a1, logic w1,
                              logic e2, logic [9:0] a2, logic w2,
                              logic mack, logic [31:0] mdo, logic [1:0] gnt,
                              logic [9:0] xaddr, logic k1, logic k2, logic [31:0] xdo);
    vec_t v;
    v.rst = rst; v.e1 = e1; v.a1 = a1; v.w1 = w1; v.e2 = e2; v.a2 = a2; v.w2 = w2;
    v.mack = mack; v.mdo = mdo; v.gnt = gnt; v.xaddr = xaddr;
    v.k1 = k1; v.k2 = k2; v.xdo = xdo;
    return v;
  endfunction

  task automatic drive(logic rst, logic e1, logic [9:0] a1, logic w1,
                       logic e2, logic [9:0] a2, logic w2, logic mack, logic [31:0] mdo);
    reset = rst;
    dev1_mem_en = e1; dev1_mem_addr = a1; dev1_mem_we = w1;
    dev2_mem_en = e2; dev2_mem_addr = a2; dev2_mem_we = w2;
    mem_do_ack = mack; mem_do = mdo;
  endtask

  task automatic chk(string nm, logic xen, logic [9:0] xaddr, logic xwe, logic [31:0] xdi,
                     logic xk1, logic xk2, logic [31:0] xdo, logic xerr);
    n_vec++;
    if (mem_en !== xen) begin
      n_miss++; $display("FAIL %s mem_en got %b want %b", nm, mem_en, xen);
    end
    if (mem_addr !== xaddr) begin
      n_miss++; $display("FAIL %s mem_addr got %h want %h", nm, mem_addr, xaddr);
    end
    if (mem_we !== xwe) begin
      n_miss++; $display("FAIL %s mem_we got %b want %b", nm, mem_we, xwe);
    end
    if (mem_di !== xdi) begin
      n_miss++; $display("FAIL %s mem_di got %h want %h", nm, mem_di, xdi);
    end
    if (dev1_do_ack !== xk1) begin
      n_miss++; $display("FAIL %s dev1_do_ack got %b want %b", nm, dev1_do_ack, xk1);
    end
    if (dev2_do_ack !== xk2) begin
      n_miss++; $display("FAIL %s dev2_do_ack got %b want %b", nm, dev2_do_ack, xk2);
    end
    if ((xk1 || xk2) && (dev_do !== xdo)) begin
      n_miss++; $display("FAIL %s dev_do got %h want %h", nm, dev_do, xdo);
    end
    if (timeout_err !== xerr) begin
      n_miss++; $display("FAIL %s timeout_err got %b want %b", nm, timeout_err, xerr);
    end
    if (mem_burst_en !== 1'b0) begin
      n_miss++; $display("FAIL %s mem_burst_en got %b want 0", nm, mem_burst_en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    dev1_mem_di = DI1;
    dev2_mem_di = DI2;
    drive(1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 32'h0);

    // rst e1 a1 w1 e2 a2 w2 mack mdo | gnt xaddr k1 k2 xdo
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 0 reset state
    vt.push_back(mk(1,1,10'h005,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 1 request sampled
    vt.push_back(mk(1,1,10'h005,0, 0,10'h000,0, 0,32'h0,        1,10'h005,0,0,32'h0));        // 2 mem_en rises
    vt.push_back(mk(1,1,10'h005,0, 0,10'h000,0, 0,32'h0,        1,10'h005,0,0,32'h0));
    vt.push_back(mk(1,1,10'h005,0, 0,10'h000,0, 0,32'h0,        1,10'h005,0,0,32'h0));
    vt.push_back(mk(1,1,10'h005,0, 0,10'h000,0, 1,32'hCAFEF00D, 1,10'h005,1,0,32'hCAFEF00D)); // 5 ack
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 1,32'h12345678, 0,10'h000,0,0,32'h0));        // 6 stray ack in IDLE
    vt.push_back(mk(1,1,10'h00A,1, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 7 write request
    vt.push_back(mk(1,1,10'h00A,1, 0,10'h000,0, 1,32'h0,        1,10'h00A,1,0,32'h0));        // 8 immediate ack
    vt.push_back(mk(1,1,10'h00A,1, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 9 late drop masked
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 10 no re-grant
    vt.push_back(mk(0,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 11 reset
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 12 tie after reset
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        1,10'h010,0,0,32'h0));        // 13 dev1 first
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000A1, 1,10'h010,1,0,32'h000000A1));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 15 idle gap
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000B2, 2,10'h020,0,1,32'h000000B2)); // 16 dev2
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000C1, 1,10'h010,1,0,32'h000000C1));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000C2, 2,10'h020,0,1,32'h000000C2));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000C3, 1,10'h010,1,0,32'h000000C3));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h010,0, 1,10'h020,0, 1,32'h000000C4, 2,10'h020,0,1,32'h000000C4)); // 24
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h030,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h030,0, 0,10'h000,0, 1,32'h000000D1, 1,10'h030,1,0,32'h000000D1));
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h040,0, 1,10'h050,0, 0,32'h0,        0,10'h000,0,0,32'h0));        // 29 tie, dev1 last
    vt.push_back(mk(1,1,10'h040,0, 1,10'h050,0, 1,32'h000000D2, 2,10'h050,0,1,32'h000000D2)); // 30 dev2 wins
    vt.push_back(mk(1,1,10'h040,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h040,0, 0,10'h000,0, 1,32'h000000D3, 1,10'h040,1,0,32'h000000D3));
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,1,10'h060,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,0,10'h060,0, 0,10'h000,0, 0,32'h0,        1,10'h060,0,0,32'h0));        // 35 en dropped, held
    vt.push_back(mk(1,0,10'h060,0, 0,10'h000,0, 1,32'h000000E1, 1,10'h060,1,0,32'h000000E1));
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(1,0,10'h000,0, 1,10'h070,1, 0,32'h0,        0,10'h000,0,0,32'h0));
    vt.push_back(mk(0,0,10'h000,0, 1,10'h070,1, 0,32'h0,        2,10'h070,0,0,32'h0));        // 39 reset in GNT2
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 1,32'h00000BAD, 0,10'h000,0,0,32'h0));        // 40 late RAM ack
    vt.push_back(mk(1,0,10'h000,0, 0,10'h000,0, 0,32'h0,        0,10'h000,0,0,32'h0));

    repeat (2) @(negedge clk);

    foreach (vt[i]) begin
      logic [31:0] xdi;
      logic        xwe;
      string       nm;
      xdi = (vt[i].gnt == 2'd1) ? DI1 : (vt[i].gnt == 2'd2) ? DI2 : 32'h0;
      xwe = (vt[i].gnt == 2'd1) ? vt[i].w1 : (vt[i].gnt == 2'd2) ? vt[i].w2 : 1'b0;
      nm = $sformatf("vec%0d", i);
      drive(vt[i].rst, vt[i].e1, vt[i].a1, vt[i].w1, vt[i].e2, vt[i].a2, vt[i].w2,
            vt[i].mack, vt[i].mdo);
      #2;
      chk(nm, (vt[i].gnt != 2'd0), vt[i].xaddr, xwe, xdi, vt[i].k1, vt[i].k2, vt[i].xdo, 1'b0);
      @(negedge clk);
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    // dev1 never acked while dev2 waits; dev2 then acked exactly on its cycle 16
    drive(1'b1, 1'b1, 10'h0AA, 1'b0, 1'b1, 10'h0BB, 1'b0, 1'b0, 32'h0);
    #2; chk("to_idle", 1'b0, 10'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    for (int g = 1; g <= 16; g++) begin
      #2;
      chk($sformatf("to_g1_c%0d", g), 1'b1, 10'h0AA, 1'b0, DI1, (g == 16), 1'b0,
          32'hFFFFFFFF, (g == 16));
      @(negedge clk);
    end
    #2; chk("to_gap", 1'b0, 10'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    for (int g = 1; g <= 16; g++) begin
      if (g == 16) begin
        drive(1'b1, 1'b1, 10'h0AA, 1'b0, 1'b1, 10'h0BB, 1'b0, 1'b1, 32'h5A5A5A5A);
      end
      #2;
      chk($sformatf("to_g2_c%0d", g), 1'b1, 10'h0BB, 1'b0, DI2, 1'b0, (g == 16),
          32'h5A5A5A5A, 1'b0);
      @(negedge clk);
    end
`else
    // without the watchdog the grant is held indefinitely
    drive(1'b1, 1'b1, 10'h0AA, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
    #2; chk("hold_idle", 1'b0, 10'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    for (int g = 1; g <= 40; g++) begin
      #2;
      chk($sformatf("hold_c%0d", g), 1'b1, 10'h0AA, 1'b0, DI1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 10'h0AA, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 32'h600DF00D);
    #2; chk("hold_ack", 1'b1, 10'h0AA, 1'b0, DI1, 1'b1, 1'b0, 32'h600DF00D, 1'b0);
    @(negedge clk);
`endif
    drive(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 32'h0);
    #2; chk("end_settle", 1'b0, 10'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2; chk("end_idle", 1'b0, 10'h000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word address width.
REQ-002 Parameter DATA_W, default 32, memory data width.
REQ-003 Parameter TIMEOUT, default 16, maximum grant cycles without ack (used only with the Configuration macro).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 dev1_mem_en / dev2_mem_en  in  1  access request level, one per requester (dev1 = instruction fetch, dev2 = load/store).
REQ-007 dev1_mem_addr / dev2_mem_addr  in  ADDR_W  request address.
REQ-008 dev1_mem_di / dev2_mem_di  in  DATA_W  write data.
REQ-009 dev1_mem_we / dev2_mem_we  in  1  1 = write, 0 = read.
REQ-010 dev1_do_ack / dev2_do_ack  out  1  one-cycle completion pulse to the requester.
REQ-011 dev_do  out  DATA_W  read data, shared by both requesters, valid while the requester's ack is high.
REQ-012 mem_addr / mem_di / mem_we / mem_en  out  ADDR_W/DATA_W/1/1  single shared RAM port.
REQ-013 mem_burst_en  out  1  tied 0; no burst access.
REQ-014 mem_do_ack  in  1  RAM completion pulse; mem_do  in  DATA_W  RAM read data.
REQ-015 timeout_err  out  1  one-cycle error pulse.

Function
REQ-016 FSM states: IDLE, GNT1, GNT2.
- IDLE: no dev1_mem_en/dev2_mem_en (after masking) -> stay in IDLE.
- IDLE: exactly one requester active -> go to its GNTn.
- IDLE: both active -> grant the requester not served last (round-robin pointer last_gnt).
REQ-017 The request is sampled in IDLE; mem_en rises the following cycle, giving 1 cycle latency from request to RAM port.
REQ-018 In GNTn: mem_en = 1; mem_addr/mem_di/mem_we are driven combinationally from requester n; requester n holds its inputs until its ack.
REQ-019 In GNTn, when mem_do_ack = 1: devn_do_ack = mem_do_ack (combinational, same cycle); dev_do = mem_do; last_gnt <= n; next state IDLE.
REQ-020 devn_do_ack never asserts outside GNTn; a mem_do_ack arriving in IDLE is ignored.
REQ-021 In the IDLE cycle immediately after an ack, the just-served requester's en is masked, so a requester dropping en one cycle late is not re-granted.
REQ-022 mem_en = 0 in IDLE, which guarantees at least one idle RAM cycle between grants.
REQ-023 A requester deasserting en while granted does not abort the transaction; the grant is held until ack (or timeout).
REQ-024 Outside grant, mem_addr, mem_di and mem_we are 0.

Reset
REQ-025 When reset = 0 at a clock edge, the next state is:
- state = IDLE, last_gnt = dev2 (dev1 wins the first tie), mask cleared, timeout counter = 0;
- outputs mem_en = 0, all acks = 0, timeout_err = 0, mem_burst_en = 0.
REQ-026 Reset asserted mid-grant abandons the transaction; no ack is issued, and any mem_do_ack arriving afterwards is ignored.

Configuration
REQ-027 Macro MEM_ARBITER_TIMEOUT_EN controls a grant watchdog.
- Defined: a counter runs while in GNTn. If TIMEOUT cycles pass without mem_do_ack, then in cycle TIMEOUT of the grant: devn_do_ack = 1, dev_do = all-ones, timeout_err = 1, last_gnt <= n, next state IDLE. A mem_do_ack arriving in that same cycle takes precedence: normal ack, no error.
- Undefined: no counter; the grant is held indefinitely; timeout_err is tied 0.

Verification
REQ-028 Single read: dev1 en, addr=0x005, RAM acks 3 cycles after mem_en with mem_do=0xCAFEF00D -> mem_en rises 1 cycle after request; dev1_do_ack is a 1-cycle pulse with dev_do=0xCAFEF00D; dev2_do_ack stays 0.
REQ-029 Simultaneous requests after reset: dev1 addr=0x010, dev2 addr=0x020, both held -> dev1 is served first, then one IDLE cycle, then dev2; mem_addr shows 0x010 then 0x020.
REQ-030 Fairness: both requesters re-request continuously for 6 transactions -> grants alternate 1,2,1,2,1,2; no requester is served twice in a row.
REQ-031 Late drop: dev1 keeps en high one cycle after its ack, with dev2 idle -> no second dev1 grant is issued; mem_en stays 0.
REQ-032 Reset mid-grant: reset = 0 during GNT2, then RAM acks -> mem_en = 0 the next cycle; dev2_do_ack stays 0.
REQ-033 With MEM_ARBITER_TIMEOUT_EN and TIMEOUT=16: the RAM never acks dev1 -> in grant cycle 16, dev1_do_ack = 1, dev_do = 0xFFFFFFFF, timeout_err = 1, and a pending dev2 is granted next.
